// File: rtl/vga_sync.sv
// 640x480@60 VGA timing generator: pixel-rate divider, h/v counters, registered syncs.
// Define VGA_SYNC_ACTIVE_LOW_EN for negative-polarity hsync/vsync; default is active-high.
module vga_sync #(
  parameter int CLK_DIV   = 2,
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       clk,
  input  logic       reset,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       p_tick,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
  localparam logic [9:0] HS_FIRST = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_LAST  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_LAST  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

`ifdef VGA_SYNC_ACTIVE_LOW_EN
  localparam logic SYNC_ON = 1'b0;
`else
  localparam logic SYNC_ON = 1'b1;
`endif

  logic [DIV_W-1:0] div_q, div_d;
  logic             p_tick_q, p_tick_d;
  logic [9:0]       h_q, h_d;
  logic [9:0]       v_q, v_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;

  always_comb begin
    div_d    = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
    p_tick_d = (div_d == DIV_LAST);
    h_d      = h_q;
    v_d      = v_q;
    if (p_tick_q) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 10'd1;
      end
    end
    // Syncs are decoded from the next-state counters so the registered
    // outputs line up with pixel_x/pixel_y rather than lagging one tick.
    hsync_d = ((h_d >= HS_FIRST) && (h_d <= HS_LAST)) ? SYNC_ON : ~SYNC_ON;
    vsync_d = ((v_d >= VS_FIRST) && (v_d <= VS_LAST)) ? SYNC_ON : ~SYNC_ON;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q    <= '0;
      p_tick_q <= 1'b0;
      h_q      <= '0;
      v_q      <= '0;
      hsync_q  <= ~SYNC_ON;
      vsync_q  <= ~SYNC_ON;
    end else begin
      div_q    <= div_d;
      p_tick_q <= p_tick_d;
      h_q      <= h_d;
      v_q      <= v_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
    end
  end

  assign hsync    = hsync_q;
  assign vsync    = vsync_q;
  assign p_tick   = p_tick_q;
  assign pixel_x  = h_q;
  assign pixel_y  = v_q;
  assign video_on = (h_q < H_VIS) && (v_q < V_VIS);

endmodule

// File: tb/tb_vga_sync.sv
// Directed bench for vga_sync: a default 640x480 instance and a reduced-geometry
// instance (CLK_DIV=3, 16x13 totals) so whole frames fit in a short run.
`timescale 1ns/1ps
module tb_vga_sync;

`ifdef VGA_SYNC_ACTIVE_LOW_EN
  localparam logic ACT = 1'b0;
`else
  localparam logic ACT = 1'b1;
`endif

  localparam int B_FRAME = 16 * 13 * 3;  // clks per frame of the reduced instance

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  int   k_a = 0;  // clks since last reset release, per instance
  int   k_b = 0;
  int   n_vec = 0;
  int   n_miss = 0;

  always @(posedge clk) begin
    k_a <= rst_a ? 0 : k_a + 1;
    k_b <= rst_b ? 0 : k_b + 1;
  end

  logic       a_hs, a_vs, a_vid, a_pt;
  logic [9:0] a_x, a_y;
  logic       b_hs, b_vs, b_vid, b_pt;
  logic [9:0] b_x, b_y;
  logic [23:0] got_a, got_b;
  assign got_a = {a_x, a_y, a_vid, a_hs, a_vs, a_pt};
  assign got_b = {b_x, b_y, b_vid, b_hs, b_vs, b_pt};

  vga_sync u_a (
    .clk(clk), .reset(rst_a), .hsync(a_hs), .vsync(a_vs), .video_on(a_vid),
    .p_tick(a_pt), .pixel_x(a_x), .pixel_y(a_y)
  );

  vga_sync #(
    .CLK_DIV(3), .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_DISPLAY(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
  ) u_b (
    .clk(clk), .reset(rst_b), .hsync(b_hs), .vsync(b_vs), .video_on(b_vid),
    .p_tick(b_pt), .pixel_x(b_x), .pixel_y(b_y)
  );

  // Expected outputs k clks after reset release: pixel count = k / div.
  function automatic logic [23:0] model(input int k, input int d, input int hd, input int hf,
                                        input int hsw, input int hb, input int vd, input int vf,
                                        input int vsw, input int vb);
    int ht, vt, tot, x, y;
    logic vid, hs, vs, pt;
    ht  = hd + hf + hsw + hb;
    vt  = vd + vf + vsw + vb;
    tot = k / d;
    x   = tot % ht;
    y   = (tot / ht) % vt;
    pt  = (k > 0) && ((k % d) == d - 1);
    vid = (x < hd) && (y < vd);
    hs  = (x >= hd + hf && x < hd + hf + hsw) ? ACT : ~ACT;
    vs  = (y >= vd + vf && y < vd + vf + vsw) ? ACT : ~ACT;
    return {10'(x), 10'(y), vid, hs, vs, pt};
  endfunction

  function automatic logic [23:0] exp_a(input int k);
    return model(k, 2, 640, 16, 96, 48, 480, 10, 2, 33);
  endfunction

  function automatic logic [23:0] exp_b(input int k);
    return model(k, 3, 8, 2, 3, 3, 6, 2, 2, 3);
  endfunction

  task automatic test_reset();
    logic [23:0] e;
    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    e = {10'd0, 10'd0, 1'b1, ~ACT, ~ACT, 1'b0};
    n_vec++;
    if (got_a !== e) begin
      n_miss++;
      $display("FAIL reset_a got=%h want=%h", got_a, e);
    end
    n_vec++;
    if (got_b !== e) begin
      n_miss++;
      $display("FAIL reset_b got=%h want=%h", got_b, e);
    end
    rst_a = 1'b0;
    rst_b = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk);
      #1;
      n_vec++;
      if (a_pt !== ((i % 2) == 1)) begin
        n_miss++;
        $display("FAIL tick_a clk=%0d got=%b want=%b", i, a_pt, (i % 2) == 1);
      end
      n_vec++;
      if (b_pt !== ((i % 3) == 2)) begin
        n_miss++;
        $display("FAIL tick_b clk=%0d got=%b want=%b", i, b_pt, (i % 3) == 2);
      end
    end
  endtask

  task automatic test_horizontal();
    int hs_cnt;
    logic [23:0] e;
    hs_cnt = 0;
    while (k_a < 1604) begin
      @(posedge clk);
      #1;
      e = exp_a(k_a);
      n_vec++;
      if (got_a !== e) begin
        n_miss++;
        $display("FAIL h_scan k=%0d got x=%0d y=%0d vid=%b hs=%b vs=%b pt=%b want x=%0d y=%0d vid=%b hs=%b vs=%b pt=%b",
                 k_a, got_a[23:14], got_a[13:4], got_a[3], got_a[2], got_a[1], got_a[0],
                 e[23:14], e[13:4], e[3], e[2], e[1], e[0]);
      end
      if ((k_a % 2 == 0) && (k_a / 2 < 800) && (a_hs === ACT)) hs_cnt++;
    end
    n_vec++;
    if (hs_cnt !== 96) begin
      n_miss++;
      $display("FAIL hsync_width got=%0d want=96", hs_cnt);
    end
  endtask

  task automatic test_polarity();
    int on_cnt, off_cnt;
    on_cnt  = 0;
    off_cnt = 0;
    for (int i = 0; i < 1600; i++) begin
      @(posedge clk);
      #1;
      if (a_hs === ACT) on_cnt++;
      else if (a_hs === ~ACT) off_cnt++;
    end
    n_vec++;
    if (on_cnt !== 192) begin
      n_miss++;
      $display("FAIL hsync_active_clks got=%0d want=192", on_cnt);
    end
    n_vec++;
    if (off_cnt !== 1408) begin
      n_miss++;
      $display("FAIL hsync_idle_clks got=%0d want=1408", off_cnt);
    end
  endtask

  task automatic test_vertical();
    int vs_cnt;
    logic [23:0] e;
    vs_cnt = 0;
    for (int i = 0; i < 2 * B_FRAME; i++) begin
      @(posedge clk);
      #1;
      e = exp_b(k_b);
      n_vec++;
      if (got_b !== e) begin
        n_miss++;
        $display("FAIL v_scan k=%0d got x=%0d y=%0d vid=%b hs=%b vs=%b pt=%b want x=%0d y=%0d vid=%b hs=%b vs=%b pt=%b",
                 k_b, got_b[23:14], got_b[13:4], got_b[3], got_b[2], got_b[1], got_b[0],
                 e[23:14], e[13:4], e[3], e[2], e[1], e[0]);
      end
      if (b_vs === ACT) vs_cnt++;
    end
    // Two frames, two sync lines each, 16 pixels of 3 clks.
    n_vec++;
    if (vs_cnt !== 192) begin
      n_miss++;
      $display("FAIL vsync_width got=%0d want=192", vs_cnt);
    end
  endtask

  task automatic test_frame_period();
    int   edges[3];
    int   n_edge;
    logic prev;
    n_edge = 0;
    prev   = b_vs;
    for (int i = 0; i < 3 * B_FRAME + 10 && n_edge < 3; i++) begin
      @(posedge clk);
      #1;
      if (prev === ~ACT && b_vs === ACT) begin
        edges[n_edge] = i;
        n_edge++;
      end
      prev = b_vs;
    end
    n_vec++;
    if (n_edge !== 3) begin
      n_miss++;
      $display("FAIL frame_edges got=%0d want=3", n_edge);
    end else begin
      for (int j = 1; j < 3; j++) begin
        n_vec++;
        if (edges[j] - edges[j-1] !== B_FRAME) begin
          n_miss++;
          $display("FAIL frame_period got=%0d want=%0d", edges[j] - edges[j-1], B_FRAME);
        end
      end
    end
  endtask

  task automatic test_reset_midframe();
    logic [23:0] e;
    logic found, prev;
    int   edges[2];
    int   n_edge;
    found = 1'b0;
    for (int i = 0; i < B_FRAME + 10 && !found; i++) begin
      @(posedge clk);
      #1;
      e = exp_b(k_b);
      if (e[23:14] == 10'd12 && e[13:4] == 10'd9) found = 1'b1;
    end
    n_vec++;
    if (!found) begin
      n_miss++;
      $display("FAIL midframe_reach got=none want=(12,9)");
    end
    rst_b = 1'b1;
    @(posedge clk);
    #1;
    rst_b = 1'b0;
    e = {10'd0, 10'd0, 1'b1, ~ACT, ~ACT, 1'b0};
    n_vec++;
    if (got_b !== e) begin
      n_miss++;
      $display("FAIL midframe_reset got=%h want=%h", got_b, e);
    end
    n_edge = 0;
    prev   = b_vs;
    for (int i = 0; i < 2 * B_FRAME; i++) begin
      @(posedge clk);
      #1;
      e = exp_b(k_b);
      n_vec++;
      if (got_b !== e) begin
        n_miss++;
        $display("FAIL restart_scan k=%0d got=%h want=%h", k_b, got_b, e);
      end
      if (prev === ~ACT && b_vs === ACT && n_edge < 2) begin
        edges[n_edge] = k_b;
        n_edge++;
      end
      prev = b_vs;
    end
    // Line 8 starts after 8*16 pixels of 3 clks.
    n_vec++;
    if (n_edge !== 2 || edges[0] !== 384 || edges[1] !== 384 + B_FRAME) begin
      n_miss++;
      $display("FAIL restart_vsync got=%0d edges first=%0d second=%0d want first=384 second=%0d",
               n_edge, edges[0], edges[1], 384 + B_FRAME);
    end
  endtask

  initial begin
    test_reset();
    test_horizontal();
    test_polarity();
    test_vertical();
    test_frame_period();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
